data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001: Parameter DEPTH, default 256, number of 32-bit words in the array; SHALL be a power of two.
REQ-002: Parameter LATENCY, default 3, number of BUSY cycles per access; SHALL be at least 1.
REQ-003: Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004: Port reset  input  1  asynchronous, active-high reset.
REQ-005: Port mem_read  input  1  MEM-stage read request, level-held by the pipeline until stall drops.
REQ-006: Port mem_write  input  1  MEM-stage write request, level-held like mem_read.
REQ-007: Port address  input  32  word address; only bits [log2(DEPTH)-1:0] are used.
REQ-008: Port write_data  input  32  store data.
REQ-009: Port read_data  output  32  load data, registered.
REQ-010: Port stall  output  1  freeze request to PC, IF/ID, ID/EX and EX/MEM registers.
REQ-011: Port done  output  1  one-cycle pulse marking the cycle in which the access result is final.

Function
REQ-012: The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-013: In IDLE with (mem_read | mem_write) = 1, the block SHALL latch address, write_data and the operation at the clock edge, load the counter with LATENCY-1, and enter BUSY.
REQ-014: In IDLE with no request, the block SHALL remain in IDLE.
REQ-015: stall SHALL be combinational: stall = (IDLE & (mem_read | mem_write)) | BUSY; stall SHALL be 0 in DONE.
REQ-016: In BUSY, the counter SHALL decrement each cycle. At the edge where the counter equals 0, the latched access SHALL be performed and the block SHALL enter DONE.
REQ-017: A write SHALL store the latched write_data at the latched word index. A read SHALL load read_data from the latched word index.
REQ-018: If mem_read and mem_write are both 1, write SHALL take priority and read_data SHALL be left unchanged.
REQ-019: done SHALL be 1 only in DONE. DONE SHALL last exactly one cycle and then return to IDLE unconditionally. A request present during DONE SHALL be ignored, because it is the request just served.
REQ-020: Each access SHALL keep stall high for exactly LATENCY+1 consecutive cycles, followed by one cycle of stall = 0.
REQ-021: read_data SHALL hold its value except when a read completes or reset is asserted.
REQ-022: Address bits at and above log2(DEPTH) SHALL be ignored, so addresses wrap modulo DEPTH.
REQ-023: Back-to-back requests SHALL be served in sequence: IDLE follows DONE, and a request held in that IDLE cycle starts a new access.
REQ-024: Input changes during BUSY SHALL NOT affect the access in progress.

Reset
REQ-025: While reset is 1, the block SHALL go to IDLE immediately, independent of clock, and SHALL clear the counter, read_data and all DEPTH words to 0. done SHALL be 0, and stall SHALL follow REQ-015.
REQ-026: Reset asserted during BUSY or DONE SHALL abort the access; no memory write SHALL occur for an aborted access.
REQ-027: After reset deasserts, the first clock edge with a request present SHALL start an access per REQ-013.

Verification
REQ-028: Write then read, LATENCY=3. Stimulus: write 0x0000_00AB to address 5, then read address 5. Required response: stall high for 4 cycles per access, done pulses once per access, and read_data = 0x0000_00AB in the DONE cycle of the read.
REQ-029: Simultaneous request. Stimulus: mem_read = mem_write = 1, address 7, write_data 0x1234. Required response: word 7 = 0x1234 and read_data unchanged from its previous value.
REQ-030: Wrap-around, DEPTH=256. Stimulus: write 0xDEAD to address 0x0000_0103, then read address 3. Required response: read_data = 0xDEAD.
REQ-031: Reset mid-access. Stimulus: assert reset during the second BUSY cycle of a write of 0x55 to address 9, then read address 9. Required response: stall and done are 0 and the state is IDLE before the next edge, and the later read of address 9 returns 0.
REQ-032: Back-to-back. Stimulus: hold a read of address 2, then immediately a read of address 3, with LATENCY=1. Required response: stall pattern 1,1,0,1,1,0; two done pulses; read_data shows word 2, then word 3.
REQ-033: Idle and boundary LATENCY. Stimulus: no request for 10 cycles, then one read with LATENCY=1. Required response: stall = 0 and done = 0 throughout the idle period; the read shows stall for exactly 2 cycles.

Source files
------------

// File: rtl/data_memory_responder.sv
// Purpose : multi-cycle data memory for the MEM stage; serves one load/store per request.
// Latency : LATENCY+1 cycles of stall per access, result final in the single DONE cycle.
// Backpr. : stall freezes the upstream pipeline while an access is pending or in flight.
//
// Ports:
//   clock, reset          - single rising-edge clock, asynchronous active-high reset
//   mem_read, mem_write   - level-held requests; write wins when both are set
//   address               - word address, wraps modulo DEPTH
//   write_data            - store data
//   read_data             - registered load data, changes only when a read completes
//   stall                 - combinational freeze request to PC, IF/ID, ID/EX, EX/MEM
//   done                  - one-cycle pulse in the cycle the access result is final
module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata;
  logic           r_is_wr;
  logic           r_is_rd;
  logic [31:0]    r_read_data;
  logic [31:0]    r_mem [DEPTH];

  logic           w_req;
  logic           w_fire;
  logic [AW-1:0]  w_idx;
  // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
  logic [31-AW:0] w_unused_addr_hi;

  assign w_req            = mem_read | mem_write;
  assign w_idx            = address[AW-1:0];
  assign w_unused_addr_hi = address[31:AW];
  // The access is performed on the edge that ends the last BUSY cycle.
  assign w_fire           = (r_state == S_BUSY) && (r_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_is_rd     <= 1'b0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Everything the access needs is captured here, so inputs
            // wiggling during BUSY cannot disturb it.
            r_idx   <= w_idx;
            r_wdata <= write_data;
            r_is_wr <= mem_write;
            r_is_rd <= mem_read & ~mem_write;
            r_cnt   <= CNT_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            if (r_is_rd) begin
              r_read_data <= r_mem[r_idx];
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          // The request still visible here is the one just served.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset clears the whole array; an access aborted by reset never reaches w_fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_fire && r_is_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign read_data = r_read_data;
  assign stall     = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_data_memory_responder.sv
// Purpose : directed self-checking bench for data_memory_responder (LATENCY 3 and 1 instances).
// Latency : checks stall/done/read_data every cycle of each access.
// Backpr. : requests are held through the stall window and the DONE cycle, as a pipeline would.
module tb_data_memory_responder;

  logic        clock;
  logic        reset;

  logic        rd3, wr3, rd1, wr1;
  logic [31:0] a3, d3, a1, d1;
  logic [31:0] q3, q1;
  logic        st3, st1, dn3, dn1;

  int n_cmp = 0;
  int n_err = 0;
  bit sel;   // 0: LATENCY=3 instance, 1: LATENCY=1 instance

  data_memory_responder #(.DEPTH(256), .LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .mem_read(rd3), .mem_write(wr3),
    .address(a3), .write_data(d3), .read_data(q3), .stall(st3), .done(dn3)
  );

  data_memory_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mem_read(rd1), .mem_write(wr1),
    .address(a1), .write_data(d1), .read_data(q1), .stall(st1), .done(dn1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd1 = r; wr1 = w; a1 = a; d1 = d;
    end else begin
      rd3 = r; wr3 = w; a3 = a; d3 = d;
    end
  endtask

  function automatic logic [31:0] o_q();
    return sel ? q1 : q3;
  endfunction
  function automatic logic o_st();
    return sel ? st1 : st3;
  endfunction
  function automatic logic o_dn();
    return sel ? dn1 : dn3;
  endfunction

  // One access: expects stall=1 for lat+1 cycles, then a DONE cycle with
  // stall=0, done=1 and the given read_data. The request stays held through
  // DONE; the task returns one tick into the following IDLE cycle.
  task automatic access(input int lat, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_q, input bit scramble, input string tag);
    drive(r, w, a, d);
    for (int c = 0; c <= lat; c++) begin
      #1;
      chk($sformatf("%s_stall%0d", tag, c), {31'd0, o_st()}, 32'd1);
      chk($sformatf("%s_done%0d", tag, c), {31'd0, o_dn()}, 32'd0);
      @(posedge clock); #1;
      if (scramble) drive(r, w, a ^ 32'h0000_0047, ~d);
    end
    #1;
    chk({tag, "_done_stall"}, {31'd0, o_st()}, 32'd0);
    chk({tag, "_done_pulse"}, {31'd0, o_dn()}, 32'd1);
    chk({tag, "_rdata"}, o_q(), exp_q);
    @(posedge clock); #1;
  endtask

  // Requests dropped; stall/done must stay low and read_data must hold.
  task automatic idle(input int n, input logic [31:0] exp_q, input string tag);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int c = 0; c < n; c++) begin
      #1;
      chk($sformatf("%s_stall%0d", tag, c), {31'd0, o_st()}, 32'd0);
      chk($sformatf("%s_done%0d", tag, c), {31'd0, o_dn()}, 32'd0);
      chk($sformatf("%s_hold%0d", tag, c), o_q(), exp_q);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    rd3 = 0; wr3 = 0; a3 = 0; d3 = 0;
    rd1 = 0; wr1 = 0; a1 = 0; d1 = 0;
    #2;
    chk("rst_q3", q3, 32'd0);
    chk("rst_st3", {31'd0, st3}, 32'd0);
    chk("rst_dn3", {31'd0, dn3}, 32'd0);
    chk("rst_q1", q1, 32'd0);
    chk("rst_st1", {31'd0, st1}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #1;

    // ---- LATENCY=3 instance ----
    sel = 1'b0;
    // Write then read address 5.
    access(3, 1'b0, 1'b1, 32'd5, 32'h0000_00AB, 32'd0, 1'b0, "wr5");
    access(3, 1'b1, 1'b0, 32'd5, 32'd0, 32'h0000_00AB, 1'b0, "rd5");
    idle(2, 32'h0000_00AB, "idle_a");

    // Simultaneous read+write: write wins, read_data untouched.
    access(3, 1'b1, 1'b1, 32'd7, 32'h0000_1234, 32'h0000_00AB, 1'b0, "rw7");
    idle(1, 32'h0000_00AB, "idle_b");
    access(3, 1'b1, 1'b0, 32'd7, 32'd0, 32'h0000_1234, 1'b0, "rd7");
    idle(1, 32'h0000_1234, "idle_c");

    // Wrap-around, with inputs scrambled during BUSY (would hit word 0x44).
    access(3, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_DEAD, 32'h0000_1234, 1'b1, "wr103");
    idle(1, 32'h0000_1234, "idle_d");
    access(3, 1'b1, 1'b0, 32'd3, 32'd0, 32'h0000_DEAD, 1'b0, "rd3w");
    access(3, 1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'd0, 1'b0, "rd44");
    idle(1, 32'd0, "idle_e");

    // Reset during the second BUSY cycle of a write of 0x55 to address 9.
    drive(1'b0, 1'b1, 32'd9, 32'h0000_0055);
    @(posedge clock); #1;          // first BUSY cycle
    @(posedge clock); #1;          // second BUSY cycle
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("abort_st", {31'd0, st3}, 32'd0);
    chk("abort_dn", {31'd0, dn3}, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #1;
    access(3, 1'b1, 1'b0, 32'd9, 32'd0, 32'd0, 1'b0, "rd9");
    access(3, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 1'b0, "rd5clr");
    idle(1, 32'd0, "idle_f");

    // ---- LATENCY=1 instance ----
    sel = 1'b1;
    idle(10, 32'd0, "idle10");
    access(1, 1'b0, 1'b1, 32'd2, 32'h0000_0022, 32'd0, 1'b0, "wr2");
    access(1, 1'b0, 1'b1, 32'd3, 32'h0000_0033, 32'd0, 1'b0, "wr3");
    // Back-to-back reads: stall 1,1,0,1,1,0.
    access(1, 1'b1, 1'b0, 32'd2, 32'd0, 32'h0000_0022, 1'b0, "b2b2");
    access(1, 1'b1, 1'b0, 32'd3, 32'd0, 32'h0000_0033, 1'b0, "b2b3");
    idle(2, 32'h0000_0033, "idle_g");

    // The other instance must not have been disturbed.
    chk("q3_hold", q3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
